// File: rtl/dut_capture_reader_pkg.sv
// Shared definitions for the capture reader.
// Contents:
//   - FSM state encoding. The values are fixed so the encoding stays the same as
//     the older encoded-constant version.
//   - Default chain geometry and timing.
//   - capture_latency(): the number of cycles from the edge that samples START
//     to the cycle in which DONE is high.
package dut_capture_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_SETTLE   = 3'd2,
    ST_SHIFT_HI = 3'd3,
    ST_SHIFT_LO = 3'd4,
    ST_FINISH   = 3'd5
  } state_e;

  localparam int unsigned DEF_CHAIN_BITS = 32;
  localparam int unsigned DEF_CLK_DIV    = 4;
  localparam int unsigned DEF_PL_CYCLES  = 4;

  function automatic int unsigned capture_latency(input int unsigned chain_bits,
                                                  input int unsigned clk_div,
                                                  input int unsigned pl_cycles);
    return 1 + pl_cycles + clk_div + 2 * clk_div * chain_bits;
  endfunction

endpackage

// File: rtl/dut_capture_reader_tick.sv
// capture_tick_gen: a loadable down-counter that marks the last cycle of a phase.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous reset, active low
//   load_i  - reload the counter; a new phase starts on the next cycle
//   len_i   - length of the new phase in cycles (must be 1 or more)
//   tick_o  - high during the final cycle of the current phase
module capture_tick_gen #(
  parameter int unsigned W = 3
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] len_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;

  // Loading len-1 puts the tick in cycle number len of the phase.
  // A length of 1 therefore ticks in the first cycle of the phase.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= len_i - 1'b1;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/dut_capture_reader.sv
// dut_capture_reader: reads DUT response bits back from a chain of
// parallel-in/serial-out shift registers.
// Sequence of one capture:
//   1. Pulse PL_BAR low to load the chain.
//   2. Wait for the chain output to settle.
//   3. Clock SHCP CHAIN_BITS times and sample Q, MSB first.
// When the last bit is in, the block presents the word on DATA and pulses DONE.
// Ports:
//   CLK    - clock
//   RST    - asynchronous reset, active low
//   START  - capture request; only sampled in IDLE
//   BUSY   - high while a capture is in progress
//   DONE   - one-cycle strobe; DATA is valid from this cycle
//   DATA   - captured word; the first serial bit is in DATA[CHAIN_BITS-1]
//   PL_BAR - parallel-load strobe to the chain, active low
//   SHCP   - shift clock to the chain
//   Q      - serial data from the chain
module dut_capture_reader
  import dut_capture_reader_pkg::*;
#(
  parameter int unsigned CHAIN_BITS = DEF_CHAIN_BITS,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned PL_CYCLES  = DEF_PL_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CHAIN_BITS-1:0] DATA,
  output logic                  PL_BAR,
  output logic                  SHCP,
  input  logic                  Q
);

  localparam int unsigned DIV_MAX = (CLK_DIV > PL_CYCLES) ? CLK_DIV : PL_CYCLES;
  localparam int unsigned DIV_W   = $clog2(DIV_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(CHAIN_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_BITS - 1);

  state_e                  state_q, state_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CHAIN_BITS-1:0]   sreg_q;
  logic [CHAIN_BITS-1:0]   data_q;
  logic                    busy_q, done_q, pl_bar_q, shcp_q, entry_q;
  logic                    tick, tick_load;
  logic [DIV_W-1:0]        tick_len;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_LOAD;
          bit_cnt_d = '0;
        end
      end
      ST_LOAD:     if (tick) state_d = ST_SETTLE;
      ST_SETTLE:   if (tick) state_d = ST_SHIFT_HI;
      ST_SHIFT_HI: if (tick) state_d = ST_SHIFT_LO;
      ST_SHIFT_LO: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_FINISH;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            state_d   = ST_SHIFT_HI;
          end
        end
      end
      ST_FINISH:   state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // The phase timer restarts on every state change.
  // Only LOAD uses PL_CYCLES; all other phases last CLK_DIV cycles.
  assign tick_load = (state_d != state_q);
  assign tick_len  = (state_d == ST_LOAD) ? DIV_W'(PL_CYCLES) : DIV_W'(CLK_DIV);

  capture_tick_gen #(
    .W(DIV_W)
  ) u_tick (
    .clk_i  (CLK),
    .rst_ni (RST),
    .load_i (tick_load),
    .len_i  (tick_len),
    .tick_o (tick)
  );

  // The outputs follow state_q, so they are one cycle behind the FSM.
  // Effect: Q is sampled at the end of the SHIFT_HI entry cycle, and the
  // registered SHCP rise only appears after that edge. This keeps the first
  // bit from being lost to an early shift.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      entry_q   <= 1'b0;
      sreg_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pl_bar_q  <= 1'b1;
      shcp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      entry_q   <= tick_load;
      if (state_q == ST_SHIFT_HI && entry_q) begin
        sreg_q <= {sreg_q[CHAIN_BITS-2:0], Q};
      end
      pl_bar_q <= (state_q != ST_LOAD);
      shcp_q   <= (state_q == ST_SHIFT_HI);
      done_q   <= (state_q == ST_FINISH);
      if (state_q == ST_FINISH) begin
        data_q <= sreg_q;
        busy_q <= 1'b0;
      end else if (state_q == ST_IDLE && START) begin
        busy_q <= 1'b1;
      end
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign DATA   = data_q;
  assign PL_BAR = pl_bar_q;
  assign SHCP   = shcp_q;

endmodule

// File: tb/tb_dut_capture_reader.sv
module tb_dut_capture_reader;

  localparam int N8  = 8;
  localparam int D8  = 2;
  localparam int P8  = 2;
  localparam int LAT8 = 1 + P8 + D8 + 2 * D8 * N8;          // 37
  localparam int N32 = 32;
  localparam int D32 = 4;
  localparam int P32 = 4;
  localparam int LAT32 = 1 + P32 + D32 + 2 * D32 * N32;     // 265

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Small instance
  logic       RST8, START8, Q8, BUSY8, DONE8, PL8, SH8;
  logic [7:0] DATA8;
  logic [7:0] pins8, ch8;

  dut_capture_reader #(.CHAIN_BITS(N8), .CLK_DIV(D8), .PL_CYCLES(P8)) dut8 (
    .CLK(CLK), .RST(RST8), .START(START8), .BUSY(BUSY8), .DONE(DONE8),
    .DATA(DATA8), .PL_BAR(PL8), .SHCP(SH8), .Q(Q8)
  );

  // Default instance
  logic        RST32, START32, Q32, BUSY32, DONE32, PL32, SH32;
  logic [31:0] DATA32;
  logic [31:0] pins32, ch32;

  dut_capture_reader #(.CHAIN_BITS(N32), .CLK_DIV(D32), .PL_CYCLES(P32)) dut32 (
    .CLK(CLK), .RST(RST32), .START(START32), .BUSY(BUSY32), .DONE(DONE32),
    .DATA(DATA32), .PL_BAR(PL32), .SHCP(SH32), .Q(Q32)
  );

  // Chain model: load the pin image on a PL_BAR fall; shift toward the MSB
  // on each SHCP rise. Q is the MSB.
  always @(negedge PL8 or posedge SH8) begin
    if (!PL8) ch8 <= pins8;
    else      ch8 <= ch8 << 1;
  end
  assign Q8 = ch8[7];

  always @(negedge PL32 or posedge SH32) begin
    if (!PL32) ch32 <= pins32;
    else       ch32 <= ch32 << 1;
  end
  assign Q32 = ch32[31];

  // Free-running event counters; tests take differences between snapshots.
  int rises8 = 0, falls8 = 0, pllow8 = 0, shhi8 = 0, dones8 = 0, rises32 = 0;
  always @(posedge SH8)  rises8++;
  always @(negedge PL8)  falls8++;
  always @(posedge SH32) rises32++;
  always @(posedge CLK) begin
    if (PL8 === 1'b0)  pllow8++;
    if (SH8 === 1'b1)  shhi8++;
    if (DONE8 === 1'b1) dones8++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One capture on the small instance.
  // If extra is set, START is also pulsed 5 and 20 cycles into the capture.
  task automatic capture8(input logic [7:0] val, input bit extra, input string tag);
    int r0, f0, l0, h0, d0, t0, rel, lat;
    bit got;
    pins8 = val;
    @(negedge CLK);
    r0 = rises8; f0 = falls8; l0 = pllow8; h0 = shhi8; d0 = dones8;
    START8 = 1'b1;
    t0 = cyc + 1;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge CLK);
      rel = cyc - t0;
      START8 = extra && (rel == 5 || rel == 20);
      if (DONE8 === 1'b1) begin
        got = 1'b1;
        lat = rel;
      end
    end
    START8 = 1'b0;
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, lat, LAT8);
    check({tag, " data"}, DATA8, val);
    check({tag, " busy after"}, BUSY8, 1'b0);
    repeat (6) @(negedge CLK);
    check({tag, " shcp rises"}, rises8 - r0, N8);
    check({tag, " pl falls"}, falls8 - f0, 1);
    check({tag, " pl low cycles"}, pllow8 - l0, P8);
    check({tag, " shcp high cycles"}, shhi8 - h0, D8 * N8);
    check({tag, " done pulses"}, dones8 - d0, 1);
  endtask

  task automatic capture32(input logic [31:0] val, input string tag);
    int r0, t0, lat;
    bit got;
    pins32 = val;
    @(negedge CLK);
    r0 = rises32;
    START32 = 1'b1;
    t0 = cyc + 1;
    @(negedge CLK);
    START32 = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (DONE32 === 1'b1) begin
        got = 1'b1;
        lat = cyc - t0;
      end else begin
        @(negedge CLK);
      end
    end
    check({tag, " done seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, lat, LAT32);
    check({tag, " data"}, DATA32, val);
    repeat (4) @(negedge CLK);
    check({tag, " shcp rises"}, rises32 - r0, N32);
  endtask

  initial begin
    logic [7:0] held [3];
    int t0, k, dprev;
    RST8 = 1'b0; RST32 = 1'b0;
    START8 = 1'b0; START32 = 1'b0;
    pins8 = '0; pins32 = '0;
    repeat (3) @(negedge CLK);

    check("rst busy", BUSY8, 1'b0);
    check("rst done", DONE8, 1'b0);
    check("rst data", DATA8, 8'h00);
    check("rst pl_bar", PL8, 1'b1);
    check("rst shcp", SH8, 1'b0);
    check("rst data32", DATA32, 32'h0);
    RST8 = 1'b1; RST32 = 1'b1;
    repeat (2) @(negedge CLK);

    // Single capture and fixed patterns
    capture8(8'hA5, 1'b0, "single a5");
    capture8(8'h00, 1'b0, "pat 00");
    capture8(8'hFF, 1'b0, "pat ff");
    capture8(8'h01, 1'b0, "pat 01");
    capture8(8'h80, 1'b0, "pat 80");

    // START pulses while busy must be dropped
    capture8(8'h69, 1'b1, "start busy");

    // Reset in the middle of the shift phase
    pins8 = 8'h5A;
    @(negedge CLK);
    START8 = 1'b1;
    t0 = cyc + 1;
    @(negedge CLK);
    START8 = 1'b0;
    repeat (10) @(negedge CLK);
    check("midrst shcp high before", SH8, 1'b1);
    check("midrst busy before", BUSY8, 1'b1);
    #1 RST8 = 1'b0;
    #1;
    check("midrst pl_bar", PL8, 1'b1);
    check("midrst shcp", SH8, 1'b0);
    check("midrst busy", BUSY8, 1'b0);
    check("midrst data", DATA8, 8'h00);
    @(negedge CLK);
    RST8 = 1'b1;
    repeat (2) @(negedge CLK);
    capture8(8'hC7, 1'b0, "after rst");

    // Random patterns
    for (int i = 0; i < 4; i++) begin
      capture8(8'($urandom_range(0, 255)), 1'b0, "random");
    end

    // START held high: back-to-back captures
    held[0] = 8'h3C; held[1] = 8'hC3; held[2] = 8'h5A;
    pins8 = held[0];
    @(negedge CLK);
    START8 = 1'b1;
    t0 = cyc + 1;
    k = 0;
    dprev = 0;
    for (int i = 0; i < 400 && k < 3; i++) begin
      @(negedge CLK);
      if (DONE8 === 1'b1) begin
        check("held data", DATA8, held[k]);
        if (k == 0) check("held first latency", cyc - t0, LAT8);
        else        check("held spacing", cyc - dprev, LAT8 + 1);
        dprev = cyc;
        k++;
        if (k < 3) pins8 = held[k];
        else       START8 = 1'b0;
      end
    end
    START8 = 1'b0;
    check("held captures", k, 3);
    repeat (4) @(negedge CLK);
    check("held idle after", BUSY8, 1'b0);

    // Default geometry
    capture32(32'hDEADBEEF, "def deadbeef");
    capture32($urandom, "def random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dut_capture_reader.md
Name: dut_capture_reader

Overview:
Reads DUT response bits back from the tester's chain of parallel-in/serial-out shift registers. This is the receive-direction counterpart of the serial-to-parallel path that drives SIGNALS. On START, the block pulses PL_BAR to latch the DUT pins into the chain, then clocks SHCP and samples Q bit by bit. The assembled word goes to the central FSM with a one-cycle DONE strobe, for transfer over UART or into SRAM.

Parameters:
CHAIN_BITS, 32, total serial bits in the chain (multiple of 8, 8..256).
CLK_DIV, 4, CLK cycles per SHCP half-period and settle time (>=1).
PL_CYCLES, 4, CLK cycles PL_BAR is held low (>=1).

Ports:
CLK  input  1  global 100 MHz clock.
RST  input  1  asynchronous, active-low reset.
START  input  1  capture request; sampled only in IDLE.
BUSY  output  1  high from the cycle after START is accepted until DONE.
DONE  output  1  one-cycle pulse; DATA valid from this cycle.
DATA  output  CHAIN_BITS  captured word; first serial bit lands in DATA[CHAIN_BITS-1].
PL_BAR  output  1  parallel-load strobe to the chain, active low.
SHCP  output  1  shift clock to the chain; rising edge advances Q.
Q  input  1  serial data from the last register of the chain.

Behaviour:
- Interface: one clock, CLK. RST is asynchronous and active-low.
- Reset values (async, any state): BUSY=0, DONE=0, DATA=0, PL_BAR=1, SHCP=0; state forced to IDLE; bit/divider counters cleared. Reset mid-capture abandons the capture; DATA is not partially updated.
- All outputs are registered; no combinational path from input to output.
- IDLE: PL_BAR=1, SHCP=0. START=1 moves to LOAD next cycle and sets BUSY.
- LOAD: PL_BAR=0 for exactly PL_CYCLES cycles, then SETTLE.
- SETTLE: PL_BAR=1, SHCP=0 for CLK_DIV cycles (chain output settling), then SHIFT_HI.
- SHIFT_HI (entry cycle):
  - Sample Q into the internal shift register, MSB-first: sreg <= {sreg[CHAIN_BITS-2:0], Q}.
  - Drive SHCP=1, hold for CLK_DIV cycles, then SHIFT_LO.
- SHIFT_LO: SHCP=0 for CLK_DIV cycles.
  - If the bit counter equals CHAIN_BITS-1, go to FINISH.
  - Otherwise increment the counter and go to SHIFT_HI.
- Q sampling: Q is sampled in the SHIFT_HI entry cycle, i.e. before the registered SHCP rise is visible. Q is therefore stable for at least CLK_DIV cycles after the previous falling edge or after SETTLE.
- Pulse count: exactly CHAIN_BITS SHCP pulses per capture. The final pulse is harmless.
- FINISH (one cycle):
  - DATA <= sreg, DONE=1, BUSY=0, next state IDLE.
  - A START in this cycle is ignored.
- START while BUSY: ignored, no queuing.
- START held high continuously: back-to-back captures; a new capture begins on the cycle after each return to IDLE.
- Latency: DONE asserts exactly 1 + PL_CYCLES + CLK_DIV + 2*CLK_DIV*CHAIN_BITS cycles after the START-sampled edge. With defaults this is 265 cycles.
- Bit counter width: clog2(CHAIN_BITS). Divider width: clog2(max(CLK_DIV, PL_CYCLES)+1). Counters never wrap inside a capture.

Decomposition:
- Shared package:
  - state encoding (IDLE, LOAD, SETTLE, SHIFT_HI, SHIFT_LO, FINISH);
  - default CHAIN_BITS, CLK_DIV, PL_CYCLES;
  - the latency formula as a constant function for the bench.
- One sub-module: capture_tick_gen, a loadable down-counter. It produces a one-cycle expiry tick for the LOAD, SETTLE and SHIFT phase durations; the FSM reloads it on each state entry.

Test Plan (CHAIN_BITS=8, CLK_DIV=2, PL_CYCLES=2 unless noted):
- Reset mid-SHIFT: assert RST at cycle 10 after START -> PL_BAR=1, SHCP=0, BUSY=0, DATA=0 immediately. After release, a fresh START works normally.
- Single capture: chain model preloaded with 0xA5, pulse START -> PL_BAR low exactly 2 cycles, 8 SHCP pulses each 2 high/2 low, DONE at cycle 37, DATA=0xA5.
- Patterns: repeat the single capture with 0x00, 0xFF, 0x01, 0x80 -> DATA equals the loaded value each time (checks MSB-first order and end bits).
- START during BUSY: extra START pulses at cycles 5 and 20 -> exactly one DONE, no extra PL_BAR pulse.
- START held high: 3 consecutive captures with chain values 0x3C, 0xC3, 0x5A -> DONE spacing 38 cycles, DATA matches each value.
- Defaults (CHAIN_BITS=32, CLK_DIV=4, PL_CYCLES=4), chain 0xDEADBEEF -> DONE at cycle 265, DATA=0xDEADBEEF, 32 SHCP rising edges counted.
